lab4_net_router_output_ctrl: RTL and testbench

Per-output-port controller for the ring router. Arbitrates among the three input-port request vectors (west, terminal, east) targeting this output. Tracks downstream buffer occupancy with a credit counter and enforces bubble flow control on terminal injection. Its grant bit feeds back to each input terminal controller's grants input, and its num_free output drives their num_free_west/num_free_east inputs.

---
 rtl/lab4_net_router_output_ctrl.sv | 86 ++++++++
 tb/tb_lab4_net_router_output_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lab4_net_router_output_ctrl.sv
// Per-output-port controller for the ring router: round-robin arbitration over
// west/terminal/east requests, downstream credit tracking and bubble flow control.
module lab4_net_router_output_ctrl #(
    parameter  int p_num_reqs     = 3,
    parameter  int p_credit_max   = 4,
    parameter  int p_inject_idx   = 1,
    localparam int c_credit_nbits = $clog2(p_credit_max + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_num_reqs-1:0]     reqs,
    output logic [p_num_reqs-1:0]     grants,
    output logic                      out_val,
    input  logic                      credit_return,
    output logic [c_credit_nbits-1:0] num_free
);

    localparam logic [c_credit_nbits-1:0] c_credit_one  = c_credit_nbits'(1);
    localparam logic [c_credit_nbits-1:0] c_credit_two  = c_credit_nbits'(2);
    localparam logic [c_credit_nbits-1:0] c_credit_full = c_credit_nbits'(p_credit_max);
    localparam logic [p_num_reqs-1:0]     c_req_one     = p_num_reqs'(1);

    logic [c_credit_nbits-1:0] credits;
    logic [c_credit_nbits-1:0] credits_next;
    logic [p_num_reqs-1:0]     ptr;
    logic [p_num_reqs-1:0]     ptr_next;
    logic [p_num_reqs-1:0]     eligible;
    logic [p_num_reqs-1:0]     masked;
    logic [p_num_reqs-1:0]     grant_raw;
    logic                      xfer;

    // The injection port may never take the last free slot, so it needs two credits.
    for (genvar g = 0; g < p_num_reqs; g++) begin : g_elig
        if (g == p_inject_idx) begin : g_inject
            assign eligible[g] = reqs[g] && (credits >= c_credit_two);
        end else begin : g_through
            assign eligible[g] = reqs[g] && (credits >= c_credit_one);
        end
    end

    // Round-robin pick: lowest eligible bit at or above the pointer, else wrap to the lowest overall.
    always_comb begin
        masked    = eligible & ~(ptr - c_req_one);
        grant_raw = '0;
        if (masked != '0) begin
            grant_raw = masked & (~masked + c_req_one);
        end else begin
            grant_raw = eligible & (~eligible + c_req_one);
        end
    end

    assign grants   = reset ? grant_raw : '0;
    assign out_val  = |grants;
    assign xfer     = out_val;
    assign num_free = credits;

    always_comb begin
        ptr_next     = ptr;
        credits_next = credits;
        if (xfer) begin
            ptr_next = {grants[p_num_reqs-2:0], grants[p_num_reqs-1]};
        end
        if (xfer && !credit_return) begin
            credits_next = credits - c_credit_one;
        end else if (!xfer && credit_return && (credits != c_credit_full)) begin
            credits_next = credits + c_credit_one;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= c_credit_full;
            ptr     <= c_req_one;
        end else begin
            credits <= credits_next;
            ptr     <= ptr_next;
        end
    end

`ifndef SYNTHESIS
    // A return with a full counter and nothing sent means downstream released a slot it never had.
    credit_overflow_check : assert property (@(posedge clk) disable iff (!reset)
        !(credit_return && !xfer && (credits == c_credit_full)));
`endif

endmodule

// File: tb/tb_lab4_net_router_output_ctrl.sv
// Directed, table-driven bench for the router output-port controller, plus
// hand sequences for asynchronous reset in the middle of traffic.
module tb_lab4_net_router_output_ctrl;

    typedef struct {
        logic       rst;
        logic [2:0] reqs;
        logic       ret;
        logic [2:0] exp_grants;
        logic [2:0] exp_free;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       credit_return;
    logic [2:0] num_free;

    int total;
    int bad;
    vec_t vecs[$];

    lab4_net_router_output_ctrl dut (
        .clk(clk),
        .reset(reset),
        .reqs(reqs),
        .grants(grants),
        .out_val(out_val),
        .credit_return(credit_return),
        .num_free(num_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic rst, input logic [2:0] r, input logic ret,
                           input logic [2:0] g, input logic [2:0] nf);
        vec_t v;
        v.rst = rst;
        v.reqs = r;
        v.ret = ret;
        v.exp_grants = g;
        v.exp_free = nf;
        vecs.push_back(v);
    endtask

    // Inputs change shortly after the rising edge, well away from it.
    task automatic applyStimulus(input logic rst, input logic [2:0] r, input logic ret);
        @(posedge clk);
        #1;
        reset = rst;
        reqs = r;
        credit_return = ret;
    endtask

    task automatic compare(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic checkNow(input string tag, input logic [2:0] g, input logic [2:0] nf);
        compare({tag, " grants"}, int'(grants), int'(g));
        compare({tag, " out_val"}, int'(out_val), int'(|g));
        compare({tag, " num_free"}, int'(num_free), int'(nf));
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] g, input logic [2:0] nf);
        @(negedge clk);
        checkNow(tag, g, nf);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        reqs = 3'b000;
        credit_return = 1'b0;

        // Full round-robin drain from reset down to zero credits.
        add_vec(0, 3'b000, 0, 3'b000, 3'd4);
        add_vec(1, 3'b111, 0, 3'b001, 3'd4);
        add_vec(1, 3'b111, 0, 3'b010, 3'd3);
        add_vec(1, 3'b111, 0, 3'b100, 3'd2);
        add_vec(1, 3'b111, 0, 3'b001, 3'd1);
        add_vec(1, 3'b111, 0, 3'b000, 3'd0);
        // Bubble rule at one credit, then a through request takes the last slot.
        add_vec(0, 3'b000, 0, 3'b000, 3'd4);
        add_vec(1, 3'b111, 0, 3'b001, 3'd4);
        add_vec(1, 3'b111, 0, 3'b010, 3'd3);
        add_vec(1, 3'b111, 0, 3'b100, 3'd2);
        add_vec(1, 3'b010, 0, 3'b000, 3'd1);
        add_vec(1, 3'b011, 0, 3'b001, 3'd1);
        add_vec(1, 3'b000, 0, 3'b000, 3'd0);
        // Zero credits: a return re-enables the held east request.
        add_vec(1, 3'b100, 1, 3'b000, 3'd0);
        add_vec(1, 3'b100, 0, 3'b100, 3'd1);
        add_vec(1, 3'b000, 0, 3'b000, 3'd0);
        // Steady state: send and return every cycle keeps the count at full.
        add_vec(0, 3'b000, 0, 3'b000, 3'd4);
        add_vec(1, 3'b001, 1, 3'b001, 3'd4);
        add_vec(1, 3'b001, 1, 3'b001, 3'd4);
        add_vec(1, 3'b001, 1, 3'b001, 3'd4);
        add_vec(1, 3'b001, 1, 3'b001, 3'd4);
        add_vec(1, 3'b000, 0, 3'b000, 3'd4);
        // Pointer wraps from index 2 back to 0, then moves on to 1.
        add_vec(0, 3'b000, 0, 3'b000, 3'd4);
        add_vec(1, 3'b001, 1, 3'b001, 3'd4);
        add_vec(1, 3'b010, 1, 3'b010, 3'd4);
        add_vec(1, 3'b011, 1, 3'b001, 3'd4);
        add_vec(1, 3'b011, 1, 3'b010, 3'd4);
        add_vec(1, 3'b000, 0, 3'b000, 3'd4);
        // Injection is still allowed at exactly two credits.
        add_vec(0, 3'b000, 0, 3'b000, 3'd4);
        add_vec(1, 3'b111, 0, 3'b001, 3'd4);
        add_vec(1, 3'b111, 0, 3'b010, 3'd3);
        add_vec(1, 3'b010, 0, 3'b010, 3'd2);
        add_vec(1, 3'b010, 0, 3'b000, 3'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].reqs, vecs[i].ret);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_grants, vecs[i].exp_free);
        end

        // Reset dropped between edges while a grant is active at one credit.
        applyStimulus(0, 3'b000, 0);
        checkOutput("rst0", 3'b000, 3'd4);
        applyStimulus(1, 3'b111, 0);
        checkOutput("run0", 3'b001, 3'd4);
        applyStimulus(1, 3'b111, 0);
        checkOutput("run1", 3'b010, 3'd3);
        applyStimulus(1, 3'b111, 0);
        checkOutput("run2", 3'b100, 3'd2);
        applyStimulus(1, 3'b111, 0);
        checkOutput("run3", 3'b001, 3'd1);
        #2;
        reset = 1'b0;
        #1;
        checkNow("async_rst", 3'b000, 3'd4);

        // Returns arriving while reset is held must not be counted.
        credit_return = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        credit_return = 1'b0;
        reset = 1'b1;
        reqs = 3'b111;
        checkOutput("post_rst0", 3'b001, 3'd4);
        applyStimulus(1, 3'b111, 0);
        checkOutput("post_rst1", 3'b010, 3'd3);
        applyStimulus(1, 3'b000, 0);
        checkOutput("post_rst2", 3'b000, 3'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
